ad9361_status_monitor: RTL

- Receive-side counterpart to the AD9361 misc control outputs: samples the CTRL_OUT status buses (gpio_status_0/1) and clock-select straps from up to two AD9361 devices, synchronises and glitch-filters them.
- Keeps sticky rise flags and change counters per device, and presents everything to the processor on the 64-bit gpio_i readback word plus a maskable interrupt.
- Sits alongside the misc IO block, between the AD9361 pins and the PS GPIO/interrupt fabric.

---
 rtl/ad9361_status_monitor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ad9361_status_monitor.sv
// ---------------------------------------------------------------------------
// ad9361_status_monitor
//
// Purpose:
//   Watches the CTRL_OUT status buses and clock-select straps coming back
//   from up to two AD9361 devices. Each asynchronous input is brought into
//   the clk domain through a two-flop synchroniser. The status bytes are
//   then glitch-filtered so that only values held for STABLE_CYCLES edges
//   are accepted. Per device the block keeps sticky rise flags and a
//   saturating change counter. Everything is presented on a 64-bit readback
//   word, and a maskable level interrupt is also driven.
//
// Configuration:
//   AD9361_STATUS_DUAL_EN - when defined, device 1 is fully monitored.
//                           When undefined, device 1 logic is not built.
//                           In that case its readback fields read 0 and
//                           irq_mask[15:8] has no effect.
//
// Parameters:
//   STABLE_CYCLES - edges a synchronised status vector must hold before it
//                   is accepted (legal range 1..15).
//
// Ports:
//   clk           - system clock
//   rst           - synchronous, active-high reset
//   gpio_status_0 - device 0 CTRL_OUT (async)
//   gpio_clksel_0 - device 0 clock-select strap (async)
//   gpio_status_1 - device 1 CTRL_OUT (async)
//   gpio_clksel_1 - device 1 clock-select strap (async)
//   sticky_clr    - bit n clears device n sticky flags and change counter
//   irq_mask      - [7:0] device 0 sticky enables, [15:8] device 1
//   gpio_i        - status readback word
//   irq           - level interrupt
// ---------------------------------------------------------------------------

// One device worth of synchroniser, filter, sticky flags and change counter.
module Ad9361StatusChannel #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] status_i,
  input  logic       clksel_i,
  input  logic       clr_i,
  output logic [7:0] filt_o,
  output logic [7:0] sticky_o,
  output logic [7:0] count_o,
  output logic       clksel_o
);

  localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

  logic [7:0] syncS1_q;
  logic [7:0] syncS2_q;
  logic       clkS1_q;
  logic       clkS2_q;
  logic [7:0] cand_q;
  logic [7:0] cand_d;
  logic [3:0] stab_q;
  logic [3:0] stab_d;
  logic [7:0] filt_q;
  logic [7:0] filt_d;
  logic [7:0] sticky_q;
  logic [7:0] sticky_d;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       filtChanged;

  // Next-state for the glitch filter and the bookkeeping that hangs off it.
  // The candidate always tracks the synchronised value; the stability
  // counter restarts whenever the candidate moves and saturates once the
  // value has been seen long enough. The filtered value is taken from the
  // next-state candidate so that STABLE_CYCLES=1 accepts on the same edge
  // the candidate is captured.
  // Sticky flags give priority to a new rise over a clear, and the change
  // counter reloads to 1 if a clear coincides with a filtered change.
  always_comb begin
    cand_d = syncS2_q;

    if (syncS2_q != cand_q) begin
      stab_d = 4'd1;
    end else if (stab_q < STABLE_LIMIT) begin
      stab_d = stab_q + 4'd1;
    end else begin
      stab_d = stab_q;
    end

    filt_d = filt_q;
    if ((stab_d == STABLE_LIMIT) && (cand_d != filt_q)) begin
      filt_d = cand_d;
    end

    filtChanged = (filt_d != filt_q);

    sticky_d = (sticky_q & ~{8{clr_i}}) | (filt_d & ~filt_q);

    if (clr_i) begin
      count_d = {7'd0, filtChanged};
    end else if (filtChanged && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State registers. Reset returns every stage, including the
  // synchronisers, to zero so filtering restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncS1_q <= 8'd0;
      syncS2_q <= 8'd0;
      clkS1_q  <= 1'b0;
      clkS2_q  <= 1'b0;
      cand_q   <= 8'd0;
      stab_q   <= 4'd0;
      filt_q   <= 8'd0;
      sticky_q <= 8'd0;
      count_q  <= 8'd0;
    end else begin
      syncS1_q <= status_i;
      syncS2_q <= syncS1_q;
      clkS1_q  <= clksel_i;
      clkS2_q  <= clkS1_q;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      filt_q   <= filt_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign filt_o   = filt_q;
  assign sticky_o = sticky_q;
  assign count_o  = count_q;
  assign clksel_o = clkS2_q;

endmodule

module ad9361_status_monitor #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gpio_status_0,
  input  logic        gpio_clksel_0,
  input  logic [7:0]  gpio_status_1,
  input  logic        gpio_clksel_1,
  input  logic [1:0]  sticky_clr,
  input  logic [15:0] irq_mask,
  output logic [63:0] gpio_i,
  output logic        irq
);

  logic [7:0] filt0;
  logic [7:0] sticky0;
  logic [7:0] count0;
  logic       clksel0;
  logic [7:0] filt1;
  logic [7:0] sticky1;
  logic [7:0] count1;
  logic       clksel1;
  logic       irq_q;

  Ad9361StatusChannel #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) channel0 (
    .clk      (clk),
    .rst      (rst),
    .status_i (gpio_status_0),
    .clksel_i (gpio_clksel_0),
    .clr_i    (sticky_clr[0]),
    .filt_o   (filt0),
    .sticky_o (sticky0),
    .count_o  (count0),
    .clksel_o (clksel0)
  );

`ifdef AD9361_STATUS_DUAL_EN
  Ad9361StatusChannel #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) channel1 (
    .clk      (clk),
    .rst      (rst),
    .status_i (gpio_status_1),
    .clksel_i (gpio_clksel_1),
    .clr_i    (sticky_clr[1]),
    .filt_o   (filt1),
    .sticky_o (sticky1),
    .count_o  (count1),
    .clksel_o (clksel1)
  );
`else
  // Single-device build: device 1 inputs are intentionally ignored and its
  // readback fields are held at zero.
  logic unusedDev1;
  assign unusedDev1 = ^{gpio_status_1, gpio_clksel_1, sticky_clr[1]};
  assign filt1   = 8'd0;
  assign sticky1 = 8'd0;
  assign count1  = 8'd0;
  assign clksel1 = 1'b0;
`endif

  // The interrupt is computed from the registered sticky flags. It
  // therefore rises one edge after the sticky bit that causes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |({sticky1, sticky0} & irq_mask);
    end
  end

  assign irq = irq_q;

  // Readback is a direct view of the registers, so it adds no latency.
  assign gpio_i = {8'd0, count1, count0, 6'd0, clksel1, clksel0,
                   sticky1, sticky0, filt1, filt0};

endmodule
